// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus an optional 16-step shift-add multiplier.
// The multiplier is built only when EXECUTE_STAGE_MUL_EN is defined.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_id,
    input  logic [3:0]  control_id,
    input  logic [15:0] operand_a_id,
    input  logic [15:0] operand_b_id,
    input  logic [15:0] reg_data_id,
    input  logic [4:0]  dest_reg_index_id,
    input  logic        dest_reg_write_en_id,
    input  logic        flush_ex,
    output logic        stall_ex,
    output logic [3:0]  control_ex,
    output logic [15:0] result_ex,
    output logic [15:0] reg_data_ex,
    output logic [4:0]  dest_reg_index_ex,
    output logic        dest_reg_write_en_ex
);

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpAnd   = 4'b0010;
    localparam logic [3:0] OpOr    = 4'b0011;
    localparam logic [3:0] OpXor   = 4'b0100;
    localparam logic [3:0] OpNot   = 4'b0101;
    localparam logic [3:0] OpSll   = 4'b0110;
    localparam logic [3:0] OpSrl   = 4'b0111;
    localparam logic [3:0] OpMul   = 4'b1000;
    localparam logic [3:0] OpLoad  = 4'b1100;
    localparam logic [3:0] OpStore = 4'b1110;
    localparam logic [3:0] OpNop   = 4'b1111;

    logic [3:0]  control_q, control_d;
    logic [15:0] result_q, result_d;
    logic [15:0] reg_data_q, reg_data_d;
    logic [4:0]  dest_idx_q, dest_idx_d;
    logic        dest_we_q, dest_we_d;

    logic [15:0] alu_result;
    logic        exec_we;
    logic        accept;

    always_comb begin
        alu_result = '0;
        case (control_id)
            OpAdd:   alu_result = operand_a_id + operand_b_id;
            OpSub:   alu_result = operand_a_id - operand_b_id;
            OpAnd:   alu_result = operand_a_id & operand_b_id;
            OpOr:    alu_result = operand_a_id | operand_b_id;
            OpXor:   alu_result = operand_a_id ^ operand_b_id;
            OpNot:   alu_result = ~operand_a_id;
            OpSll:   alu_result = operand_a_id << operand_b_id[3:0];
            OpSrl:   alu_result = operand_a_id >> operand_b_id[3:0];
            OpLoad:  alu_result = operand_a_id + operand_b_id;
            OpStore: alu_result = operand_a_id + operand_b_id;
            default: alu_result = '0;
        endcase
    end

    assign exec_we = (control_id == OpStore || control_id == OpNop) ? 1'b0 : dest_reg_write_en_id;

`ifdef EXECUTE_STAGE_MUL_EN
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] mul_a_q, mul_a_d;
    logic [15:0] mul_b_q, mul_b_d;
    logic [15:0] prod_q, prod_d;
    logic [15:0] mul_reg_data_q, mul_reg_data_d;
    logic [4:0]  mul_dest_idx_q, mul_dest_idx_d;
    logic        mul_dest_we_q, mul_dest_we_d;
    logic [15:0] prod_next;

    // One shift-add step per cycle, bit step_q of the multiplier.
    assign prod_next = prod_q + (mul_b_q[step_q] ? (mul_a_q << step_q) : 16'h0000);
    assign stall_ex  = (state_q == StBusy);
    assign accept    = valid_id && !flush_ex && !stall_ex;

    always_comb begin
        control_d      = control_q;
        result_d       = result_q;
        reg_data_d     = reg_data_q;
        dest_idx_d     = dest_idx_q;
        dest_we_d      = dest_we_q;
        state_d        = state_q;
        step_d         = step_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        prod_d         = prod_q;
        mul_reg_data_d = mul_reg_data_q;
        mul_dest_idx_d = mul_dest_idx_q;
        mul_dest_we_d  = mul_dest_we_q;

        if (state_q == StBusy) begin
            if (flush_ex) begin
                state_d   = StIdle;
                step_d    = '0;
                control_d = OpNop;
                result_d  = '0;
                dest_we_d = 1'b0;
            end else if (step_q == 4'hF) begin
                state_d    = StIdle;
                step_d     = '0;
                prod_d     = prod_next;
                control_d  = OpMul;
                result_d   = prod_next;
                reg_data_d = mul_reg_data_q;
                dest_idx_d = mul_dest_idx_q;
                dest_we_d  = mul_dest_we_q;
            end else begin
                step_d    = step_q + 4'd1;
                prod_d    = prod_next;
                control_d = OpNop;
                result_d  = '0;
                dest_we_d = 1'b0;
            end
        end else if (accept && control_id == OpMul) begin
            state_d        = StBusy;
            step_d         = '0;
            prod_d         = '0;
            mul_a_d        = operand_a_id;
            mul_b_d        = operand_b_id;
            mul_reg_data_d = reg_data_id;
            mul_dest_idx_d = dest_reg_index_id;
            mul_dest_we_d  = dest_reg_write_en_id;
            control_d      = OpNop;
            result_d       = '0;
            dest_we_d      = 1'b0;
        end else if (accept) begin
            control_d  = control_id;
            result_d   = alu_result;
            reg_data_d = reg_data_id;
            dest_idx_d = dest_reg_index_id;
            dest_we_d  = exec_we;
        end else begin
            control_d = OpNop;
            result_d  = '0;
            dest_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            step_q         <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            prod_q         <= '0;
            mul_reg_data_q <= '0;
            mul_dest_idx_q <= '0;
            mul_dest_we_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            prod_q         <= prod_d;
            mul_reg_data_q <= mul_reg_data_d;
            mul_dest_idx_q <= mul_dest_idx_d;
            mul_dest_we_q  <= mul_dest_we_d;
        end
    end
`else
    assign stall_ex = 1'b0;
    assign accept   = valid_id && !flush_ex;

    // MUL without the multiplier retires as a bubble.
    always_comb begin
        control_d  = control_q;
        result_d   = result_q;
        reg_data_d = reg_data_q;
        dest_idx_d = dest_idx_q;
        dest_we_d  = dest_we_q;
        if (accept && control_id != OpMul) begin
            control_d  = control_id;
            result_d   = alu_result;
            reg_data_d = reg_data_id;
            dest_idx_d = dest_reg_index_id;
            dest_we_d  = exec_we;
        end else begin
            control_d = OpNop;
            result_d  = '0;
            dest_we_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_q  <= OpNop;
            result_q   <= '0;
            reg_data_q <= '0;
            dest_idx_q <= '0;
            dest_we_q  <= 1'b0;
        end else begin
            control_q  <= control_d;
            result_q   <= result_d;
            reg_data_q <= reg_data_d;
            dest_idx_q <= dest_idx_d;
            dest_we_q  <= dest_we_d;
        end
    end

    assign control_ex           = control_q;
    assign result_ex            = result_q;
    assign reg_data_ex          = reg_data_q;
    assign dest_reg_index_ex    = dest_idx_q;
    assign dest_reg_write_en_ex = dest_we_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; multiplier cases follow EXECUTE_STAGE_MUL_EN.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_id;
    logic [3:0]  control_id;
    logic [15:0] operand_a_id;
    logic [15:0] operand_b_id;
    logic [15:0] reg_data_id;
    logic [4:0]  dest_reg_index_id;
    logic        dest_reg_write_en_id;
    logic        flush_ex;
    logic        stall_ex;
    logic [3:0]  control_ex;
    logic [15:0] result_ex;
    logic [15:0] reg_data_ex;
    logic [4:0]  dest_reg_index_ex;
    logic        dest_reg_write_en_ex;

    int n_checks = 0;
    int n_errors = 0;

    execute_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .valid_id             (valid_id),
        .control_id           (control_id),
        .operand_a_id         (operand_a_id),
        .operand_b_id         (operand_b_id),
        .reg_data_id          (reg_data_id),
        .dest_reg_index_id    (dest_reg_index_id),
        .dest_reg_write_en_id (dest_reg_write_en_id),
        .flush_ex             (flush_ex),
        .stall_ex             (stall_ex),
        .control_ex           (control_ex),
        .result_ex            (result_ex),
        .reg_data_ex          (reg_data_ex),
        .dest_reg_index_ex    (dest_reg_index_ex),
        .dest_reg_write_en_ex (dest_reg_write_en_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] rd, input logic [4:0] idx,
                         input logic we);
        valid_id             = v;
        control_id           = op;
        operand_a_id         = a;
        operand_b_id         = b;
        reg_data_id          = rd;
        dest_reg_index_id    = idx;
        dest_reg_write_en_id = we;
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".ctl"}, control_ex, 4'hF);
        check({tag, ".res"}, result_ex, 16'h0000);
        check({tag, ".we"}, dest_reg_write_en_ex, 1'b0);
    endtask

    initial begin
        logic saw_mul;
        reset    = 1'b1;
        flush_ex = 1'b0;
        drive(1'b0, 4'hF, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        step();
        step();
        check_bubble("rst");
        check("rst.rd", reg_data_ex, 16'h0000);
        check("rst.idx", dest_reg_index_ex, 5'd0);
        check("rst.stall", stall_ex, 1'b0);

        // First instruction accepted at the first edge after release.
        reset = 1'b0;
        drive(1'b1, 4'h0, 16'hFFFF, 16'h0002, 16'h0, 5'd1, 1'b1);
        step();
        check("add.res", result_ex, 16'h0001);
        check("add.we", dest_reg_write_en_ex, 1'b1);
        check("add.ctl", control_ex, 4'h0);
        drive(1'b1, 4'h1, 16'd5, 16'd7, 16'h0, 5'd2, 1'b1);
        step();
        check("sub.res", result_ex, 16'hFFFE);
        check("sub.we", dest_reg_write_en_ex, 1'b1);
        check("sub.idx", dest_reg_index_ex, 5'd2);

        drive(1'b1, 4'h2, 16'hF0F0, 16'h0FF0, 16'h0, 5'd4, 1'b1);
        step();
        check("and.res", result_ex, 16'h00F0);
        drive(1'b1, 4'h3, 16'hF0F0, 16'h0FF0, 16'h0, 5'd4, 1'b1);
        step();
        check("or.res", result_ex, 16'hFFF0);
        drive(1'b1, 4'h4, 16'hF0F0, 16'h0FF0, 16'h0, 5'd4, 1'b1);
        step();
        check("xor.res", result_ex, 16'hFF00);
        drive(1'b1, 4'h5, 16'hF0F0, 16'h0FF0, 16'h0, 5'd4, 1'b1);
        step();
        check("not.res", result_ex, 16'h0F0F);
        drive(1'b1, 4'h6, 16'h0001, 16'h0014, 16'h0, 5'd4, 1'b1);
        step();
        check("sll.res", result_ex, 16'h0010);
        drive(1'b1, 4'h7, 16'h8000, 16'h000F, 16'h0, 5'd4, 1'b1);
        step();
        check("srl.res", result_ex, 16'h0001);

        drive(1'b1, 4'hC, 16'd10, 16'd0, 16'h0, 5'd3, 1'b1);
        step();
        check("ld.ctl", control_ex, 4'hC);
        check("ld.res", result_ex, 16'd10);
        check("ld.we", dest_reg_write_en_ex, 1'b1);
        check("ld.idx", dest_reg_index_ex, 5'd3);
        drive(1'b1, 4'hE, 16'd10, 16'd4, 16'd10, 5'd3, 1'b1);
        step();
        check("st.ctl", control_ex, 4'hE);
        check("st.res", result_ex, 16'd14);
        check("st.rd", reg_data_ex, 16'd10);
        check("st.we", dest_reg_write_en_ex, 1'b0);

        drive(1'b1, 4'hF, 16'd1, 16'd2, 16'h0, 5'd9, 1'b1);
        step();
        check_bubble("nop");

        // Invalid cycle: bubble, other fields held.
        drive(1'b1, 4'h0, 16'd3, 16'd4, 16'h1234, 5'd7, 1'b1);
        step();
        drive(1'b0, 4'h0, 16'd3, 16'd4, 16'h5555, 5'd8, 1'b1);
        step();
        check_bubble("inv");
        check("inv.idx", dest_reg_index_ex, 5'd7);
        check("inv.rd", reg_data_ex, 16'h1234);

        drive(1'b1, 4'h0, 16'd3, 16'd4, 16'h0, 5'd7, 1'b1);
        flush_ex = 1'b1;
        step();
        flush_ex = 1'b0;
        check_bubble("flush_idle");
        check("flush_idle.stall", stall_ex, 1'b0);

`ifdef EXECUTE_STAGE_MUL_EN
        // MUL 300*300; an ADD presented while stalled must be ignored.
        drive(1'b1, 4'h8, 16'd300, 16'd300, 16'hABCD, 5'd5, 1'b1);
        step();
        drive(1'b1, 4'h0, 16'd100, 16'd23, 16'h0, 5'd6, 1'b1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("mul.stall%0d", k), stall_ex, 1'b1);
            check($sformatf("mul.ctl%0d", k), control_ex, 4'hF);
            step();
        end
        check("mul.ctl", control_ex, 4'h8);
        check("mul.res", result_ex, 16'h5F90);
        check("mul.we", dest_reg_write_en_ex, 1'b1);
        check("mul.idx", dest_reg_index_ex, 5'd5);
        check("mul.stall_end", stall_ex, 1'b0);
        step();
        check("mul.next", result_ex, 16'd123);

        // MUL 7*9 flushed at edge N+5.
        drive(1'b1, 4'h8, 16'd7, 16'd9, 16'h0, 5'd5, 1'b1);
        step();
        drive(1'b0, 4'h0, 16'd0, 16'd0, 16'h0, 5'd0, 1'b0);
        repeat (4) step();
        check("mflush.stall_pre", stall_ex, 1'b1);
        flush_ex = 1'b1;
        step();
        flush_ex = 1'b0;
        check_bubble("mflush");
        check("mflush.stall", stall_ex, 1'b0);
        saw_mul = 1'b0;
        repeat (20) begin
            step();
            if (control_ex == 4'h8 || stall_ex) saw_mul = 1'b1;
        end
        check("mflush.no_mul", saw_mul, 1'b0);

        // MUL started, then reset asynchronously between edges.
        drive(1'b1, 4'h8, 16'd7, 16'd9, 16'h4321, 5'd7, 1'b1);
        step();
        drive(1'b0, 4'h0, 16'd0, 16'd0, 16'h0, 5'd0, 1'b0);
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        check_bubble("mrst");
        check("mrst.idx", dest_reg_index_ex, 5'd0);
        check("mrst.stall", stall_ex, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b1, 4'h0, 16'd1, 16'd1, 16'h0, 5'd2, 1'b1);
        step();
        check("mrst.add", result_ex, 16'd2);
        drive(1'b0, 4'h0, 16'd0, 16'd0, 16'h0, 5'd0, 1'b0);
        saw_mul = 1'b0;
        repeat (20) begin
            step();
            if (control_ex == 4'h8 || stall_ex) saw_mul = 1'b1;
        end
        check("mrst.no_mul", saw_mul, 1'b0);
`else
        drive(1'b1, 4'h8, 16'd3, 16'd4, 16'h0, 5'd5, 1'b1);
        step();
        check_bubble("mul_off");
        check("mul_off.stall", stall_ex, 1'b0);
        drive(1'b1, 4'h0, 16'd20, 16'd22, 16'h0, 5'd6, 1'b1);
        step();
        check("mul_off.next", result_ex, 16'd42);
        check("mul_off.stall2", stall_ex, 1'b0);

        // Asynchronous reset between edges clears held fields at once.
        drive(1'b1, 4'h0, 16'd3, 16'd4, 16'h4321, 5'd7, 1'b1);
        step();
        #2;
        reset = 1'b1;
        #1;
        check_bubble("arst");
        check("arst.idx", dest_reg_index_ex, 5'd0);
        check("arst.rd", reg_data_ex, 16'h0000);
        step();
        reset = 1'b0;
        drive(1'b1, 4'h0, 16'd1, 16'd1, 16'h0, 5'd2, 1'b1);
        step();
        check("arst.add", result_ex, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
